// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional performance counters are built when RISCV_MC_PERF_CNT_EN is defined.
module riscv_mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_ifetch,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       r_illegal;
    logic       w_legal;
    logic       w_is_store;
    logic       w_is_load;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_is_ifetch;
    logic       w_ir_we;
    logic       w_pc_we;
    logic [1:0] w_pc_src;
    logic [1:0] w_alu_a_sel;
    logic [1:0] w_alu_b_sel;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic [1:0] w_wb_sel;

    assign w_is_store = (opcode == OpStore);
    assign w_is_load  = (opcode == OpLoad);

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui, OpAuipc: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFetch:  if (mem_ready) w_state_next = StDecode;
            StDecode: w_state_next = w_legal ? StExec : StTrap;
            StExec: begin
                case (opcode)
                    OpR, OpI, OpLui, OpAuipc: w_state_next = StWb;
                    OpLoad, OpStore:          w_state_next = StMem;
                    OpBranch, OpJal, OpJalr:  w_state_next = StFetch;
                    default:                  w_state_next = StTrap;
                endcase
            end
            StMem:    if (mem_ready) w_state_next = w_is_store ? StFetch : StWb;
            StWb:     w_state_next = StFetch;
            StTrap:   w_state_next = StTrap;
            default:  w_state_next = StFetch;
        endcase
    end

    always_comb begin
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_is_ifetch = 1'b0;
        w_ir_we         = 1'b0;
        w_pc_we         = 1'b0;
        w_pc_src        = 2'd0;
        w_alu_a_sel     = 2'd0;
        w_alu_b_sel     = 2'd0;
        w_alu_op        = 2'b00;
        w_reg_write     = 1'b0;
        w_wb_sel        = 2'd0;
        case (r_state)
            StFetch: begin
                w_mem_req       = 1'b1;
                w_mem_is_ifetch = 1'b1;
                w_ir_we         = mem_ready;
                w_pc_we         = mem_ready;
            end
            StDecode: begin
                // Branch/JAL target OldPC+imm is registered into ALUOut here.
                w_alu_a_sel = 2'd1;
                w_alu_b_sel = 2'd1;
            end
            StExec: begin
                case (opcode)
                    OpR: w_alu_op = 2'b10;
                    OpI: begin
                        w_alu_b_sel = 2'd1;
                        w_alu_op    = 2'b10;
                    end
                    OpLoad, OpStore: w_alu_b_sel = 2'd1;
                    OpLui: begin
                        w_alu_a_sel = 2'd2;
                        w_alu_b_sel = 2'd1;
                    end
                    OpAuipc: begin
                        w_alu_a_sel = 2'd1;
                        w_alu_b_sel = 2'd1;
                    end
                    OpBranch: begin
                        w_alu_op = 2'b01;
                        w_pc_we  = branch_taken;
                        w_pc_src = 2'd1;
                    end
                    OpJal: begin
                        w_pc_we     = 1'b1;
                        w_pc_src    = 2'd1;
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'd2;
                    end
                    OpJalr: begin
                        w_alu_b_sel = 2'd1;
                        w_pc_we     = 1'b1;
                        w_pc_src    = 2'd2;
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'd2;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                w_mem_req = 1'b1;
                w_mem_we  = w_is_store;
            end
            StWb: begin
                w_reg_write = 1'b1;
                w_wb_sel    = w_is_load ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

    // Reset masks every strobe so an in-flight store cannot complete.
    assign mem_req       = w_mem_req & ~reset;
    assign mem_we        = w_mem_we & ~reset;
    assign mem_is_ifetch = w_mem_is_ifetch & ~reset;
    assign ir_we         = w_ir_we & ~reset;
    assign pc_we         = w_pc_we & ~reset;
    assign pc_src        = reset ? 2'd0 : w_pc_src;
    assign alu_a_sel     = reset ? 2'd0 : w_alu_a_sel;
    assign alu_b_sel     = reset ? 2'd0 : w_alu_b_sel;
    assign alu_op        = reset ? 2'd0 : w_alu_op;
    assign reg_write     = w_reg_write & ~reset;
    assign wb_sel        = reset ? 2'd0 : w_wb_sel;
    assign state         = r_state;
    assign illegal       = r_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_state_next == StTrap) begin
            r_illegal <= 1'b1;
        end
    end

`ifdef RISCV_MC_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_retire;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    assign w_retire = ((r_state == StExec) &&
                       (opcode == OpBranch || opcode == OpJal || opcode == OpJalr)) ||
                      ((r_state == StMem) && w_is_store && mem_ready) ||
                      (r_state == StWb);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != StTrap) r_cycle_cnt <= r_cycle_cnt + CntOne;
            if (w_retire) r_instret_cnt <= r_instret_cnt + CntOne;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl; counter expectations follow RISCV_MC_PERF_CNT_EN.
module tb_riscv_mc_ctrl;

`ifdef RISCV_MC_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    localparam logic [6:0] OpAdd    = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBad    = 7'h7F;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_is_ifetch, ir_we, pc_we, reg_write, illegal;
    logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        m4_req, m4_we, m4_if, m4_ir, m4_pc, m4_rw, m4_ill;
    logic [1:0]  m4_src, m4_a, m4_b, m4_op, m4_wb;
    logic [2:0]  m4_state;
    logic [3:0]  m4_cyc, m4_ret;

    logic [15:0] ctrl_bus;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    assign ctrl_bus = {mem_req, mem_we, mem_is_ifetch, ir_we, pc_we, pc_src, alu_a_sel,
                       alu_b_sel, alu_op, reg_write, wb_sel};

    riscv_mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_is_ifetch(mem_is_ifetch), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    riscv_mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(m4_req), .mem_we(m4_we),
        .mem_is_ifetch(m4_if), .ir_we(m4_ir), .pc_we(m4_pc), .pc_src(m4_src),
        .alu_a_sel(m4_a), .alu_b_sel(m4_b), .alu_op(m4_op),
        .reg_write(m4_rw), .wb_sel(m4_wb), .illegal(m4_ill), .state(m4_state),
        .cycle_cnt(m4_cyc), .instret_cnt(m4_ret)
    );

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
        return PerfEn ? v : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Advance to the next falling edge, apply inputs, let outputs settle.
    task automatic nxt(input logic rdy, input logic bt);
        @(negedge clk);
        mem_ready    = rdy;
        branch_taken = bt;
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = OpAdd; mem_ready = 1'b1; branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_ctrl", 32'(ctrl_bus), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_cycle", cycle_cnt, 0);

        // ADD
        @(negedge clk); reset = 1'b0; #1;
        chk("add_f_state", 32'(state), 0);
        chk("add_f_req", 32'(mem_req), 1);
        chk("add_f_ifetch", 32'(mem_is_ifetch), 1);
        chk("add_f_irwe", 32'(ir_we), 1);
        chk("add_f_pcwe", 32'(pc_we), 1);
        chk("add_f_cycle", cycle_cnt, 0);
        nxt(1, 0);
        chk("add_d_state", 32'(state), 1);
        chk("add_d_asel", 32'(alu_a_sel), 1);
        chk("add_d_bsel", 32'(alu_b_sel), 1);
        chk("add_d_req", 32'(mem_req), 0);
        nxt(1, 0);
        chk("add_e_state", 32'(state), 2);
        chk("add_e_aluop", 32'(alu_op), 2);
        chk("add_e_bsel", 32'(alu_b_sel), 0);
        chk("add_e_rw", 32'(reg_write), 0);
        nxt(1, 0);
        chk("add_w_state", 32'(state), 4);
        chk("add_w_rw", 32'(reg_write), 1);
        chk("add_w_wbsel", 32'(wb_sel), 0);
        nxt(1, 0);
        chk("add_done_state", 32'(state), 0);
        chk("add_instret", instret_cnt, exp_cnt(1));
        chk("add_cycle", cycle_cnt, exp_cnt(4));

        // LOAD with three wait cycles in MEM
        opcode = OpLoad;
        nxt(1, 0);
        chk("ld_d_state", 32'(state), 1);
        nxt(0, 0);
        chk("ld_e_state", 32'(state), 2);
        chk("ld_e_bsel", 32'(alu_b_sel), 1);
        chk("ld_e_aluop", 32'(alu_op), 0);
        for (int i = 0; i < 4; i++) begin
            nxt((i == 3) ? 1'b1 : 1'b0, 0);
            chk("ld_m_state", 32'(state), 3);
            chk("ld_m_bus", 32'({mem_req, mem_we, mem_is_ifetch}), 32'b100);
        end
        nxt(1, 0);
        chk("ld_w_state", 32'(state), 4);
        chk("ld_w_wbsel", 32'(wb_sel), 1);
        chk("ld_w_rw", 32'(reg_write), 1);
        nxt(1, 0);
        chk("ld_done_state", 32'(state), 0);
        chk("ld_cycle", cycle_cnt, exp_cnt(12));
        chk("ld_instret", instret_cnt, exp_cnt(2));

        // BEQ taken then not taken
        opcode = OpBranch;
        nxt(1, 1);
        chk("bt_d_state", 32'(state), 1);
        nxt(1, 1);
        chk("bt_e_state", 32'(state), 2);
        chk("bt_e_pcwe", 32'(pc_we), 1);
        chk("bt_e_pcsrc", 32'(pc_src), 1);
        chk("bt_e_aluop", 32'(alu_op), 1);
        nxt(1, 0);
        chk("bt_done_state", 32'(state), 0);
        chk("bt_cycle", cycle_cnt, exp_cnt(15));
        nxt(1, 0);
        nxt(1, 0);
        chk("bn_e_state", 32'(state), 2);
        chk("bn_e_pcwe", 32'(pc_we), 0);
        nxt(1, 0);
        chk("bn_done_state", 32'(state), 0);
        chk("bn_instret", instret_cnt, exp_cnt(4));

        // JALR then JAL
        opcode = OpJalr;
        nxt(1, 0);
        nxt(1, 0);
        chk("jalr_e_state", 32'(state), 2);
        chk("jalr_e_ctrl", 32'({pc_we, pc_src, reg_write, wb_sel, alu_b_sel, alu_a_sel}),
            32'b1_10_1_10_01_00);
        nxt(1, 0);
        chk("jalr_next_state", 32'(state), 0);
        opcode = OpJal;
        nxt(1, 0);
        nxt(1, 0);
        chk("jal_e_ctrl", 32'({pc_we, pc_src, reg_write, wb_sel, alu_b_sel}), 32'b1_01_1_10_00);
        nxt(1, 0);
        chk("jal_cycle", cycle_cnt, exp_cnt(24));
        chk("jal_instret", instret_cnt, exp_cnt(6));

        // STORE interrupted by reset during a wait state
        opcode = OpStore;
        nxt(1, 0);
        nxt(0, 0);
        nxt(0, 0);
        chk("st_m_state", 32'(state), 3);
        chk("st_m_bus", 32'({mem_req, mem_we, mem_is_ifetch}), 32'b110);
        nxt(0, 0);
        chk("st_m_hold", 32'({mem_req, mem_we, mem_is_ifetch}), 32'b110);
        @(negedge clk); reset = 1'b1; #1;
        chk("st_rst_req", 32'(mem_req), 0);
        chk("st_rst_we", 32'(mem_we), 0);
        chk("st_rst_state", 32'(state), 0);
        opcode = OpAdd; mem_ready = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        chk("st_rel_state", 32'(state), 0);
        chk("st_rel_req", 32'(mem_req), 1);
        chk("st_rel_instret", instret_cnt, 0);

        // 17 cycles of ADDs: 4-bit counter wraps to 1
        repeat (17) @(negedge clk);
        #1;
        chk("wrap_cyc4", 32'(m4_cyc), exp_cnt(1));
        chk("wrap_cyc32", cycle_cnt, exp_cnt(17));
        chk("wrap_instret", instret_cnt, exp_cnt(4));
        chk("wrap_state", 32'(state), 1);

        // Illegal opcode traps
        @(negedge clk); reset = 1'b1; opcode = OpBad;
        @(negedge clk); reset = 1'b0; #1;
        chk("ill_f_state", 32'(state), 0);
        nxt(1, 0);
        chk("ill_d_illegal", 32'(illegal), 0);
        nxt(1, 0);
        chk("ill_t_state", 32'(state), 5);
        chk("ill_t_flag", 32'(illegal), 1);
        chk("ill_t_ctrl", 32'(ctrl_bus), 0);
        chk("ill_t_cycle", cycle_cnt, exp_cnt(2));
        nxt(1, 1);
        nxt(1, 1);
        chk("ill_t_stay", 32'(state), 5);
        chk("ill_t_ctrl2", 32'(ctrl_bus), 0);
        chk("ill_t_frozen", cycle_cnt, exp_cnt(2));
        @(negedge clk); reset = 1'b1; #1;
        chk("ill_rst_flag", 32'(illegal), 0);
        chk("ill_rst_state", 32'(state), 0);
        opcode = OpAdd;
        @(negedge clk); reset = 1'b0; #1;
        chk("ill_rel_state", 32'(state), 0);
        chk("ill_rel_req", 32'(mem_req), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
